// File: rtl/cic_pkg.sv
// Shared CIC constants and rate-to-shift tables for the TX interpolator and RX decimator.
package cic_pkg;
    localparam int N_STAGES        = 4;
    localparam int MAX_INTERP_RATE = 128;
    localparam int MIN_SHIFT       = 6;
    localparam int MAX_SHIFT       = 21;

    // Smallest s with 2^s >= R^3, i.e. ceil(3*log2(R)); rates outside 4..128 clamp to the table ends.
    function automatic logic [4:0] interp_bitgain(input logic [8:0] rate_actual);
        logic [26:0] cube;
        logic [4:0]  s;
        cube = 27'(rate_actual) * 27'(rate_actual) * 27'(rate_actual);
        s    = 5'(MAX_SHIFT);
        if (rate_actual < 9'd4) begin
            s = 5'(MIN_SHIFT);
        end else if (rate_actual <= 9'(MAX_INTERP_RATE)) begin
            for (int k = MAX_SHIFT; k >= MIN_SHIFT; k--) begin
                if ((27'd1 << k) >= cube) s = 5'(k);
            end
        end
        return s;
    endfunction

    // Decimator counterpart: gain R^4, shift ceil(4*log2(R)).
    function automatic logic [4:0] decim_bitgain(input logic [8:0] rate_actual);
        logic [35:0] quad;
        logic [4:0]  s;
        quad = 36'(rate_actual) * 36'(rate_actual) * 36'(rate_actual) * 36'(rate_actual);
        s    = 5'd28;
        if (rate_actual < 9'd4) begin
            s = 5'd8;
        end else if (rate_actual <= 9'(MAX_INTERP_RATE)) begin
            for (int k = 28; k >= 8; k--) begin
                if ((36'd1 << k) >= quad) s = 5'(k);
            end
        end
        return s;
    endfunction
endpackage

// File: rtl/cic_int_shift_select.sv
// Combinational output slice mux: picks BW bits of the last integrator starting at the selected shift.
module cic_int_shift_select
    import cic_pkg::*;
#(
    parameter int BW = 16,
    parameter int DW = 31
) (
    input  logic [DW-1:0] data_i,
    input  logic [4:0]    shift_i,
    output logic [BW-1:0] slice_o
);
    // data_i already has the MIN_SHIFT low bits dropped; out-of-table shifts fall back to MIN_SHIFT.
    always_comb begin
        slice_o = data_i[0 +: BW];
        for (int s = MIN_SHIFT + 1; s <= MAX_SHIFT; s++) begin
            if (shift_i == 5'(s)) slice_o = data_i[(s - MIN_SHIFT) +: BW];
        end
    end
endmodule

// File: rtl/cic_interp_norm.sv
// 4-stage CIC interpolator with rate-selected right shift normalising the R^3 gain.
module cic_interp_norm
    import cic_pkg::*;
#(
    parameter int bw         = 16,
    parameter int N          = N_STAGES,
    parameter int maxbitgain = 21
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           rate,
    input  logic                 strobe_in,
    input  logic                 strobe_out,
    input  logic signed [bw-1:0] signal_in,
    output logic signed [bw-1:0] signal_out
);
    localparam int IW = bw + maxbitgain;

    logic signed [IW-1:0] comb_q  [N];
    logic signed [IW-1:0] comb_d  [N];
    logic signed [IW-1:0] dly_q   [N];
    logic signed [IW-1:0] dly_d   [N];
    logic signed [IW-1:0] integ_q [N];
    logic signed [IW-1:0] integ_d [N];
    logic                 fresh_q, fresh_d;
    logic [4:0]           shift_q, shift_d;
    logic signed [bw-1:0] out_q, out_d;
    logic signed [IW-1:0] x_in;
    logic [bw-1:0]        slice;

    cic_int_shift_select #(
        .BW (bw),
        .DW (IW - MIN_SHIFT)
    ) u_shift_select (
        .data_i  (integ_q[N-1][IW-1:MIN_SHIFT]),
        .shift_i (shift_q),
        .slice_o (slice)
    );

    always_comb begin
        comb_d  = comb_q;
        dly_d   = dly_q;
        integ_d = integ_q;
        fresh_d = fresh_q;
        out_d   = out_q;
        shift_d = interp_bitgain({1'b0, rate} + 9'd1);
        x_in    = {{maxbitgain{signal_in[bw-1]}}, signal_in};

        if (strobe_in) begin
            comb_d[0] = x_in - dly_q[0];
            dly_d[0]  = x_in;
            for (int k = 1; k < N; k++) begin
                comb_d[k] = comb_q[k-1] - dly_q[k];
                dly_d[k]  = comb_q[k-1];
            end
        end

        // Zero-stuffing: the comb result is consumed once, then zeros until the next low-rate sample.
        if (strobe_out) begin
            integ_d[0] = integ_q[0] + (fresh_q ? comb_q[N-1] : '0);
            for (int k = 1; k < N; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
            out_d   = signed'(slice);
            fresh_d = 1'b0;
        end
        if (strobe_in) fresh_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            for (int k = 0; k < N; k++) begin
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
                integ_q[k] <= '0;
            end
            fresh_q <= 1'b0;
            shift_q <= '0;
            out_q   <= '0;
        end else begin
            comb_q  <= comb_d;
            dly_q   <= dly_d;
            integ_q <= integ_d;
            fresh_q <= fresh_d;
            shift_q <= shift_d;
            out_q   <= out_d;
        end
    end

    assign signal_out = out_q;
endmodule

// File: tb/tb_cic_interp_norm.sv
// Self-checking bench for cic_interp_norm against a convolution-form reference model.
module tb_cic_interp_norm;
    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [7:0]        rate;
    logic              strobe_in;
    logic              strobe_out;
    logic signed [15:0] signal_in;
    logic signed [15:0] signal_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: low-rate input history, injected comb values indexed by strobe_out count.
    longint             x_hist [$];
    int                 inj_idx [$];
    longint             inj_val [$];
    bit                 pending;
    int                 m_out;
    logic signed [15:0] exp_out;

    always #5 clock = ~clock;

    cic_interp_norm dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .rate       (rate),
        .strobe_in  (strobe_in),
        .strobe_out (strobe_out),
        .signal_in  (signal_in),
        .signal_out (signal_out)
    );

    function automatic int ref_shift(int r);
        longint cube;
        int     s;
        if (r < 4) return 6;
        if (r > 128) return 21;
        cube = longint'(r) * r * r;
        s = 0;
        while ((longint'(1) << s) < cube) s++;
        return s;
    endfunction

    function automatic longint c3(longint k);
        if (k < 3) return 0;
        return k * (k - 1) * (k - 2) / 6;
    endfunction

    // Fourth difference of the input, delayed by the three extra comb register stages.
    function automatic longint comb_now();
        longint coef [5];
        longint acc;
        int     n;
        coef = '{1, -4, 6, -4, 1};
        acc  = 0;
        n    = x_hist.size() - 1;
        for (int j = 0; j < 5; j++) begin
            if (n - 3 - j >= 0) acc += coef[j] * x_hist[n - 3 - j];
        end
        return acc;
    endfunction

    task automatic step(input bit si, input bit so, input logic signed [15:0] din);
        longint acc;
        strobe_in  = si;
        strobe_out = so;
        signal_in  = din;
        @(posedge clock);
        if (reset || !enable) begin
            x_hist.delete();
            inj_idx.delete();
            inj_val.delete();
            pending = 0;
            m_out   = 0;
            exp_out = '0;
        end else begin
            if (so) begin
                acc = 0;
                foreach (inj_idx[i]) acc += inj_val[i] * c3(longint'(m_out - 1 - inj_idx[i]));
                exp_out = 16'(acc >>> ref_shift(int'(rate) + 1));
                if (pending) begin
                    inj_idx.push_back(m_out);
                    inj_val.push_back(comb_now());
                    pending = 0;
                end
                m_out++;
            end
            if (si) begin
                x_hist.push_back(longint'(din));
                pending = 1;
            end
        end
        #1;
    endtask

    task automatic restart(input logic [7:0] r);
        enable = 1'b0;
        rate   = r;
        step(0, 0, 16'sd0);
        step(0, 0, 16'sd0);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        rate = 8'd3;
        for (int c = 0; c < 3; c++) begin
            step(c[0], 1, 16'sd1234);
            n_checks++;
            if (signal_out !== 16'sd0) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d: signal_out=%0d expected 0", c, signal_out);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step(c % 4 == 0, 1, 16'sd1000);
            n_checks++;
            if (signal_out !== exp_out || (c == 0 && signal_out !== 16'sd0)) begin
                n_fail++;
                $display("FAIL reset_run c=%0d: signal_out=%0d expected %0d", c, signal_out, exp_out);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(c[0], 1, 16'sd1000);
            n_checks++;
            if (signal_out !== 16'sd0) begin
                n_fail++;
                $display("FAIL reset_mid c=%0d: signal_out=%0d expected 0", c, signal_out);
            end
        end
        reset = 1'b0;
        step(1, 1, 16'sd1000);
        n_checks++;
        if (signal_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_release: signal_out=%0d expected 0", signal_out);
        end
        for (int c = 0; c < 30; c++) step((c % 4) == 3, 1, 16'sd1000);
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(c[0], 1, 16'sd1000);
            n_checks++;
            if (signal_out !== 16'sd0) begin
                n_fail++;
                $display("FAIL disable_hold c=%0d: signal_out=%0d expected 0", c, signal_out);
            end
        end
        enable = 1'b1;
        step(1, 1, 16'sd1000);
        n_checks++;
        if (signal_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL disable_release: signal_out=%0d expected 0", signal_out);
        end
    endtask

    task automatic test_dc(input logic [7:0] r, input logic signed [15:0] din,
                           input logic signed [15:0] settled, input int cycles,
                           input int settle_at, input bit do_restart);
        int period;
        period = int'(r) + 1;
        if (do_restart) restart(r);
        for (int c = 0; c < cycles; c++) begin
            step(c % period == 0, 1, din);
            n_checks++;
            if (signal_out !== exp_out) begin
                n_fail++;
                $display("FAIL dc_model r=%0d c=%0d: signal_out=%0d expected %0d", r, c, signal_out, exp_out);
            end
            if (c >= settle_at) begin
                n_checks++;
                if (signal_out !== settled) begin
                    n_fail++;
                    $display("FAIL dc_settled r=%0d c=%0d: signal_out=%0d expected %0d", r, c, signal_out, settled);
                end
            end
        end
    endtask

    task automatic test_impulse();
        longint sum;
        int     first_nz;
        restart(8'd3);
        sum = 0;
        first_nz = -1;
        for (int c = 0; c < 50; c++) begin
            step(c % 4 == 0, 1, (c == 0) ? 16'sd16384 : 16'sd0);
            n_checks++;
            if (signal_out !== exp_out) begin
                n_fail++;
                $display("FAIL impulse_model c=%0d: signal_out=%0d expected %0d", c, signal_out, exp_out);
            end
            sum += longint'(signal_out);
            if (first_nz < 0 && signal_out != 16'sd0) first_nz = c;
        end
        n_checks++;
        if (first_nz < 0 || first_nz > 20) begin
            n_fail++;
            $display("FAIL impulse_start: first nonzero at %0d expected within 20 clocks", first_nz);
        end
        n_checks++;
        if (sum < 65536 - 256 || sum > 65536 + 256) begin
            n_fail++;
            $display("FAIL impulse_sum: sum=%0d expected 65536+-256", sum);
        end
        n_checks++;
        if (signal_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL impulse_tail: signal_out=%0d expected 0", signal_out);
        end
        restart(8'd3);
        for (int c = 0; c < 20; c++) step(c % 4 == 0, 1, (c == 0) ? 16'sd16384 : 16'sd0);
        n_checks++;
        if (signal_out !== exp_out) begin
            n_fail++;
            $display("FAIL impulse_pre_disable: signal_out=%0d expected %0d", signal_out, exp_out);
        end
        enable = 1'b0;
        step(0, 1, 16'sd0);
        n_checks++;
        if (signal_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL impulse_disable: signal_out=%0d expected 0", signal_out);
        end
        enable = 1'b1;
    endtask

    task automatic test_double_strobe();
        restart(8'd3);
        for (int c = 0; c < 24; c++) step(c % 4 == 0, 1, 16'($urandom_range(0, 4000)) - 16'sd2000);
        step(1, 0, 16'sd500);
        step(1, 0, 16'sd0);
        for (int c = 0; c < 40; c++) begin
            step(c % 4 == 3, 1, 16'sd0);
            n_checks++;
            if (signal_out !== exp_out) begin
                n_fail++;
                $display("FAIL double_strobe c=%0d: signal_out=%0d expected %0d", c, signal_out, exp_out);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        int         period;
        for (int round = 0; round < 3; round++) begin
            restart(8'($urandom_range(3, 20)));
            for (int c = 0; c < 300; c++) begin
                step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, 16'($urandom));
                n_checks++;
                if (signal_out !== exp_out) begin
                    n_fail++;
                    $display("FAIL random_strobes rate=%0d c=%0d: signal_out=%0d expected %0d", rate, c, signal_out, exp_out);
                end
            end
        end
        r = 8'($urandom_range(3, 127));
        period = int'(r) + 1;
        restart(r);
        for (int c = 0; c < 700; c++) begin
            step(c % period == 0, 1, 16'($urandom));
            n_checks++;
            if (signal_out !== exp_out) begin
                n_fail++;
                $display("FAIL random_periodic rate=%0d c=%0d: signal_out=%0d expected %0d", r, c, signal_out, exp_out);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        rate       = 8'd3;
        strobe_in  = 1'b0;
        strobe_out = 1'b0;
        signal_in  = 16'sd0;
        pending    = 0;
        m_out      = 0;
        exp_out    = '0;

        test_reset();
        test_dc(8'd3, 16'sd1000, 16'sd1000, 60, 40, 1);
        test_dc(8'd127, -16'sd32768, -16'sd32768, 1792, 1400, 1);
        test_dc(8'd127, 16'sd32767, 16'sd32767, 1792, 1400, 0);
        test_dc(8'd4, 16'sd1000, 16'sd976, 100, 60, 1);
        test_impulse();
        test_double_strobe();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
